vga_pixel_queue: RTL and testbench

VGA_PIXEL_QUEUE -- requirements
Module: vga_pixel_queue

---
 rtl/vga_pixel_queue.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_pixel_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_queue.sv
// vga_pixel_queue: Avalon-MM pixel plotter front-end. PLOT writes are bounds
// checked and queued in a small FIFO; a FILL write streams one colour over the
// whole screen in raster order. A drop counter records rejected PLOT writes.
module vga_pixel_queue #(
  parameter int unsigned WIDTH    = 160,
  parameter int unsigned HEIGHT   = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 8,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  // Avalon-MM slave
  input  logic [3:0]          address,
  input  logic                read,
  output logic [31:0]         readdata,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic                waitrequest,
  // Pixel stream
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_valid,
  input  logic                plot_ready
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned PIX_W = X_W + Y_W + COLOUR_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [X_W-1:0]   X_LAST   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(HEIGHT - 1);

  localparam logic [3:0] ADDR_PLOT   = 4'd0;
  localparam logic [3:0] ADDR_FILL   = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_DROP   = 4'd3;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t state_q, state_d;

  // Pixel FIFO storage and bookkeeping
  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full;
  logic             fifo_empty;

  // Fill raster position and latched colour
  logic [X_W-1:0]      fill_x_q, fill_x_d;
  logic [Y_W-1:0]      fill_y_q, fill_y_d;
  logic [COLOUR_W-1:0] fill_colour_q, fill_colour_d;

  logic [15:0] drop_cnt_q;

  // Write decode
  logic [X_W-1:0]      wr_x;
  logic [Y_W-1:0]      wr_y;
  logic [COLOUR_W-1:0] wr_colour;
  logic                in_bounds;
  logic                plot_sel, fill_sel, clr_sel;
  logic                plot_stall, fill_stall;
  logic                plot_done, fill_start;
  logic                push, pop, drop, xfer;

  logic [X_W-1:0]      head_x;
  logic [Y_W-1:0]      head_y;
  logic [COLOUR_W-1:0] head_colour;

  logic wd_unused;

  assign wr_colour = writedata[COLOUR_W-1:0];
  assign wr_x      = writedata[16 +: X_W];
  assign wr_y      = writedata[24 +: Y_W];
  assign wd_unused = ^writedata;

  assign in_bounds = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  assign plot_sel = write && (address == ADDR_PLOT);
  assign fill_sel = write && (address == ADDR_FILL);
  assign clr_sel  = reset_n && write && (address == ADDR_DROP);

  // Full is taken from the registered count, so a pop in the same cycle never
  // releases a stalled PLOT write.
  assign plot_stall = plot_sel && (fifo_full || (state_q == ST_FILL));
  assign fill_stall = fill_sel && !((state_q == ST_IDLE) && fifo_empty);

  assign waitrequest = reset_n && (plot_stall || fill_stall);

  assign plot_done  = reset_n && plot_sel && !plot_stall;
  assign push       = plot_done && in_bounds;
  assign drop       = plot_done && !in_bounds;
  assign fill_start = reset_n && fill_sel && !fill_stall;

  assign xfer = plot_valid && plot_ready;
  assign pop  = xfer && (state_q == ST_IDLE);

  assign {head_x, head_y, head_colour} = mem[rd_ptr_q];

  // Stream source select; outputs forced to zero while reset is asserted.
  always_comb begin
    plot_x      = '0;
    plot_y      = '0;
    plot_colour = '0;
    plot_valid  = 1'b0;
    if (reset_n) begin
      if (state_q == ST_FILL) begin
        plot_x      = fill_x_q;
        plot_y      = fill_y_q;
        plot_colour = fill_colour_q;
        plot_valid  = 1'b1;
      end else if (!fifo_empty) begin
        plot_x      = head_x;
        plot_y      = head_y;
        plot_colour = head_colour;
        plot_valid  = 1'b1;
      end
    end
  end

  // FIFO data array; no reset needed since outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {wr_x, wr_y, wr_colour};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Fill FSM next-state and raster counter advance.
  always_comb begin
    state_d       = state_q;
    fill_x_d      = fill_x_q;
    fill_y_d      = fill_y_q;
    fill_colour_d = fill_colour_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d       = ST_FILL;
          fill_x_d      = '0;
          fill_y_d      = '0;
          fill_colour_d = wr_colour;
        end
      end
      ST_FILL: begin
        if (xfer) begin
          if (fill_x_q == X_LAST) begin
            fill_x_d = '0;
            if (fill_y_q == Y_LAST) begin
              fill_y_d = '0;
              state_d  = ST_IDLE;
            end else begin
              fill_y_d = fill_y_q + Y_W'(1);
            end
          end else begin
            fill_x_d = fill_x_q + X_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fill FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      fill_x_q      <= '0;
      fill_y_q      <= '0;
      fill_colour_q <= '0;
    end else begin
      state_q       <= state_d;
      fill_x_q      <= fill_x_d;
      fill_y_q      <= fill_y_d;
      fill_colour_q <= fill_colour_d;
    end
  end

  // Saturating drop counter; a clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (clr_sel) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Combinational register read.
  always_comb begin
    readdata = '0;
    if (read) begin
      unique case (address)
        ADDR_STATUS: begin
          readdata[31]   = (state_q == ST_FILL);
          readdata[30]   = fifo_full;
          readdata[29]   = fifo_empty;
          readdata[15:0] = 16'(count_q);
        end
        ADDR_DROP: readdata[15:0] = drop_cnt_q;
        default:   readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_queue.sv
// Self-checking bench for vga_pixel_queue: expected pixels are queued when a
// PLOT/FILL is issued and compared as the DUT stream transfers them.
module tb_vga_pixel_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [7:0]  plot_colour;
  logic        plot_valid;
  logic        plot_ready;

  logic rdy_man, rdy_rand, rand_mode;
  assign plot_ready = rand_mode ? rdy_rand : rdy_man;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned xfers  = 0;

  logic [22:0] sb [$];

  vga_pixel_queue #(
    .WIDTH(160), .HEIGHT(120), .X_W(8), .Y_W(7), .COLOUR_W(8), .DEPTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .plot_valid(plot_valid), .plot_ready(plot_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] pix(input logic [7:0] x, input logic [6:0] y, input logic [7:0] c);
    return {x, y, c};
  endfunction

  // Random backpressure source
  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(3, 0) != 0);
  end

  // Stream monitor: hold-stability and scoreboard comparison on each transfer
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [22:0] prev_pix   = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_valid && !prev_ready)
        check("hold", 64'({plot_valid, plot_x, plot_y, plot_colour}), 64'({1'b1, prev_pix}));
      if (plot_valid && plot_ready) begin
        xfers++;
        if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
        else check("pixel", 64'({plot_x, plot_y, plot_colour}), 64'(sb.pop_front()));
      end
      prev_valid = plot_valid;
      prev_ready = plot_ready;
      prev_pix   = {plot_x, plot_y, plot_colour};
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic av_write(input logic [3:0] a, input logic [31:0] d, input int unsigned budget,
                          output int unsigned stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    address = a; writedata = d; write = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
      else begin
        stalls++;
        if (stalls >= budget) begin
          check("wr_timeout", 64'(waitrequest), 64'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic av_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    check("rd_wait", 64'(waitrequest), 64'd0);
    d = readdata;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || plot_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic push_fill(input logic [7:0] c);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        sb.push_back(pix(8'(x), 7'(y), c));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned st, n, base;
    logic [31:0] rd;
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    rdy_man = 1'b0; rand_mode = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 64'(plot_valid), 64'd0);
    check("rst_wait", 64'(waitrequest), 64'd0);
    check("rst_pix", 64'({plot_x, plot_y, plot_colour}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    av_read(4'd2, rd); check("rst_status", 64'(rd), 64'h2000_0000);
    av_read(4'd3, rd); check("rst_drop", 64'(rd), 64'd0);

    // Single PLOT, no bypass, one-cycle latency
    rdy_man = 1'b1;
    sb.push_back(pix(8'h23, 7'h05, 8'h07));
    av_write(4'd0, 32'h0523_0007, 10, st);
    check("plot_stall", 64'(st), 64'd0);
    check("plot_valid", 64'(plot_valid), 64'd1);
    check("plot_pix", 64'({plot_x, plot_y, plot_colour}), 64'(pix(8'h23, 7'h05, 8'h07)));
    @(posedge clk); #1;
    check("plot_empty", 64'(plot_valid), 64'd0);

    // Out-of-bounds drops and clear
    av_write(4'd0, {8'd0, 8'd160, 8'd0, 8'h11}, 10, st);
    av_write(4'd0, {8'd120, 8'd0, 8'd0, 8'h22}, 10, st);
    repeat (3) @(posedge clk);
    #1 check("drop_no_valid", 64'(plot_valid), 64'd0);
    av_read(4'd3, rd); check("drop_cnt", 64'(rd), 64'd2);
    av_write(4'd3, 32'h0, 10, st); check("clr_stall", 64'(st), 64'd0);
    av_read(4'd3, rd); check("drop_clr", 64'(rd), 64'd0);
    av_write(4'd5, 32'hFFFF_FFFF, 10, st); check("other_wr_stall", 64'(st), 64'd0);
    av_read(4'd7, rd); check("other_rd", 64'(rd), 64'd0);

    // Fill FIFO under backpressure, 17th stalls, conservative release
    rdy_man = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(pix(8'(i), 7'(i), 8'(i + 1)));
      av_write(4'd0, {8'(i), 8'(i), 8'd0, 8'(i + 1)}, 10, st);
    end
    address = 4'd0; writedata = {8'd20, 8'd20, 8'd0, 8'h77}; write = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_stall", 64'(waitrequest), 64'd1);
    end
    @(posedge clk); #1 write = 1'b0;
    av_read(4'd2, rd); check("status_full", 64'(rd), 64'h4000_0010);
    sb.push_back(pix(8'd20, 7'd20, 8'h77));
    rdy_man = 1'b1;
    fork
      av_write(4'd0, {8'd20, 8'd20, 8'd0, 8'h77}, 20, st);
      begin @(posedge clk); #1 rdy_man = 1'b0; end
    join
    check("full_release", 64'(st), 64'd1);
    rdy_man = 1'b1;
    wait_drain(100, "drain_full");

    // Full-screen fill with a PLOT stalled behind it
    base = xfers;
    push_fill(8'h3C);
    av_write(4'd1, 32'h0000_003C, 10, st);
    check("fill_start_stall", 64'(st), 64'd0);
    repeat (100) @(posedge clk);
    #1;
    av_read(4'd2, rd); check("status_busy", 64'(rd[31]), 64'd1);
    sb.push_back(pix(8'd1, 7'd2, 8'h55));
    av_write(4'd0, {8'd2, 8'd1, 8'd0, 8'h55}, 25000, st);
    check("plot_held_by_fill", 64'(st > 19000), 64'd1);
    wait_drain(100, "drain_fill");
    check("fill_count", 64'(xfers - base), 64'd19201);
    av_read(4'd2, rd); check("status_after_fill", 64'(rd), 64'h2000_0000);

    // Fill under random backpressure
    rand_mode = 1'b1;
    push_fill(8'hA5);
    av_write(4'd1, 32'h0000_00A5, 10, st);
    wait_drain(60000, "drain_rand_fill");
    rand_mode = 1'b0;
    rdy_man = 1'b1;

    // Reset mid-fill at (10,3)
    push_fill(8'h0F);
    av_write(4'd1, 32'h0000_000F, 10, st);
    n = 0;
    while (!(plot_valid && plot_x == 8'd10 && plot_y == 7'd3) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_10_3", 64'({plot_x, plot_y}), 64'({8'd10, 7'd3}));
    rdy_man = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_valid", 64'(plot_valid), 64'd0);
    check("midrst_pix", 64'({plot_x, plot_y, plot_colour}), 64'd0);
    check("midrst_wait", 64'(waitrequest), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rdy_man = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_rst_valid", 64'(plot_valid), 64'd0);
    end
    av_read(4'd2, rd); check("post_rst_status", 64'(rd), 64'h2000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
